// File: rtl/add_seq.sv
// add_seq: multi-cycle chunked adder/subtractor, W bits per cycle,
// least significant chunk first, carry rippled through a flop.
module add_seq #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   sum,
    output logic         ovf
);

    localparam int K  = (W > 0) ? (N / W) : 0;
    localparam int CW = (K > 2) ? $clog2(K) : 1;

    generate
        if (W < 1) begin : g_bad_w
            $error("add_seq: W must be at least 1");
        end
        if ((W > 0) && ((N % W) != 0)) begin : g_bad_div
            $error("add_seq: N must be a multiple of W");
        end
        if (K < 2) begin : g_bad_k
            $error("add_seq: N/W must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_res;
    logic          r_carry;
    logic          r_cmsb;

    logic [W:0]    w_chunk;
    logic          w_cmsb;
    logic          w_last;
    logic          w_accept;

    // The operand registers shift right by W each chunk, so the
    // adder always reads the bottom W bits: no wide mux on the path.
    assign w_chunk = {1'b0, r_a[W-1:0]}
                   + {1'b0, r_b[W-1:0]}
                   + {{W{1'b0}}, r_carry};

    // Carry into the chunk MSB, recovered from its sum bit.
    assign w_cmsb = w_chunk[W-1] ^ r_a[W-1] ^ r_b[W-1];

    assign w_last   = (r_cnt == CW'(K - 1));
    assign w_accept = in_valid && (r_state == ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Chunk counter: cleared on accept, stepped once per chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operand capture (B pre-inverted for subtract) and shift-out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_accept) begin
            r_a <= a;
            r_b <= b ^ {N{sub}};
        end else if (r_state == ST_RUN) begin
            r_a <= r_a >> W;
            r_b <= r_b >> W;
        end
    end

    // Result shifts in from the top; aligned after the last chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
        end else if (r_state == ST_RUN) begin
            r_res <= {w_chunk[W-1:0], r_res[N-1:W]};
        end
    end

    // Inter-chunk carry and carry-into-MSB for overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_cmsb  <= 1'b0;
        end else if (w_accept) begin
            r_carry <= c_in ^ sub;
        end else if (r_state == ST_RUN) begin
            r_carry <= w_chunk[W];
            if (w_last) begin
                r_cmsb <= w_cmsb;
            end
        end
    end

    // Outputs depend on registers only.
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        sum       = {r_carry, r_res};
        ovf       = r_cmsb ^ r_carry;
    end

endmodule

// File: tb/tb_add_seq.sv
// tb_add_seq: random and directed checks of add_seq at three
// N/W configurations against an arithmetic reference model.
module tb_add_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [2:0]  in_valid  = '0;
    logic [2:0]  out_ready = '0;
    logic [2:0]  cin       = '0;
    logic [2:0]  sb        = '0;
    logic [63:0] a_v [3];
    logic [63:0] b_v [3];

    wire  [2:0]  in_ready;
    wire  [2:0]  out_valid;
    wire  [2:0]  ovf;
    wire  [32:0] s0;
    wire  [10:0] s1;
    wire  [64:0] s2;

    int n_chk = 0;
    int n_err = 0;

    add_seq #(.N(32), .W(8)) u_d0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_v[0][31:0]), .b(b_v[0][31:0]),
        .c_in(cin[0]), .sub(sb[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(s0), .ovf(ovf[0])
    );

    add_seq #(.N(10), .W(5)) u_d1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_v[1][9:0]), .b(b_v[1][9:0]),
        .c_in(cin[1]), .sub(sb[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(s1), .ovf(ovf[1])
    );

    add_seq #(.N(64), .W(16)) u_d2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_v[2]), .b(b_v[2]),
        .c_in(cin[2]), .sub(sb[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(s2), .ovf(ovf[2])
    );

    function automatic int nw(input int d);
        case (d)
            0: return 32;
            1: return 10;
            default: return 64;
        endcase
    endfunction

    function automatic int nk(input int d);
        case (d)
            0: return 4;
            1: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [64:0] get_sum(input int d);
        case (d)
            0: return {32'd0, s0};
            1: return {54'd0, s1};
            default: return s2;
        endcase
    endfunction

    task automatic chk(input string tag,
                       input logic [64:0] got,
                       input logic [64:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference: plain wide integer arithmetic on n-bit operands.
    task automatic model(input int n,
                         input logic [63:0] a,
                         input logic [63:0] b,
                         input logic ci,
                         input logic s,
                         output logic [64:0] es,
                         output logic eo);
        logic [127:0] m, ua, ub, uc, t;
        logic signed [127:0] sa, sbv, sc, r, hi, lo;
        m  = (128'd1 << n) - 128'd1;
        ua = {64'd0, a} & m;
        ub = {64'd0, b} & m;
        uc = {127'd0, ci};
        if (!s) begin
            t = ua + ub + uc;
        end else begin
            t = (ua - ub - uc) & m;
            if (ua >= ub + uc) t = t | (128'd1 << n);
        end
        es  = t[64:0];
        sa  = $signed(ua);
        sbv = $signed(ub);
        sc  = $signed(uc);
        if (ua[n-1]) sa = sa - $signed(128'd1 << n);
        if (ub[n-1]) sbv = sbv - $signed(128'd1 << n);
        r  = s ? (sa - sbv - sc) : (sa + sbv + sc);
        hi = $signed((128'd1 << (n - 1)) - 128'd1);
        lo = -hi - 128'sd1;
        eo = (r > hi) || (r < lo);
    endtask

    task automatic run_op(input int d,
                          input logic [63:0] av,
                          input logic [63:0] bv,
                          input logic ci,
                          input logic s,
                          input int bp,
                          output logic [64:0] gs,
                          output logic go);
        logic [64:0] es;
        logic eo;
        int n;
        model(nw(d), av, bv, ci, s, es, eo);
        chk("idle_rdy", 65'(in_ready[d]), 65'd1);
        a_v[d] = av;
        b_v[d] = bv;
        cin[d] = ci;
        sb[d] = s;
        in_valid[d] = 1'b1;
        out_ready[d] = (bp == 0);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        if (bp > 0) begin
            a_v[d] = {$urandom, $urandom};
            b_v[d] = {$urandom, $urandom};
            cin[d] = ~ci;
            sb[d] = ~s;
            in_valid[d] = 1'b1;
        end
        n = 0;
        while (!out_valid[d] && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 65'(n), 65'(nk(d)));
        gs = get_sum(d);
        go = ovf[d];
        chk("sum", gs, es);
        chk("ovf", 65'(go), 65'(eo));
        if (bp > 0) begin
            for (int i = 0; i < bp; i++) begin
                @(posedge clk); #1;
                chk("bp_sum", get_sum(d), es);
                chk("bp_ovf", 65'(ovf[d]), 65'(eo));
                chk("bp_vld", 65'(out_valid[d]), 65'd1);
                chk("bp_rdy", 65'(in_ready[d]), 65'd0);
            end
            in_valid[d] = 1'b0;
            out_ready[d] = 1'b1;
        end
        @(posedge clk); #1;
        chk("rel_vld", 65'(out_valid[d]), 65'd0);
        chk("rel_rdy", 65'(in_ready[d]), 65'd1);
        out_ready[d] = 1'b0;
    endtask

    function automatic logic [63:0] pick(input int n);
        logic [63:0] m;
        int r;
        m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        r = $urandom_range(0, 7);
        case (r)
            0: return m;
            1: return 64'd0;
            2: return 64'd1 << (n - 1);
            default: return {$urandom, $urandom} & m;
        endcase
    endfunction

    logic [64:0] gs;
    logic go;

    initial begin
        logic [63:0] m, mp, mn;
        int bp;
        for (int i = 0; i < 3; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_rdy", 65'(in_ready[d]), 65'd1);
            chk("rst_vld", 65'(out_valid[d]), 65'd0);
            chk("rst_sum", get_sum(d), 65'd0);
            chk("rst_ovf", 65'(ovf[d]), 65'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(0, 64'd0, 64'd0, 1'b1, 1'b0, 0, gs, go);
        chk("k_zero", gs, 65'h0_00000001);
        chk("k_zero_ovf", 65'(go), 65'd0);
        run_op(0, 64'hFFFFFFFF, 64'd1, 1'b0, 1'b0, 0, gs, go);
        chk("k_ripple", gs, 65'h1_00000000);
        chk("k_ripple_ovf", 65'(go), 65'd0);
        run_op(0, 64'hFFFFFFFF, 64'hFFFFFFFF, 1'b1, 1'b0, 0, gs, go);
        chk("k_ones", gs, 65'h1_FFFFFFFF);
        run_op(0, 64'd5, 64'd7, 1'b0, 1'b1, 0, gs, go);
        chk("k_borrow", gs, 65'h0_FFFFFFFE);
        chk("k_borrow_ovf", 65'(go), 65'd0);
        run_op(0, 64'd7, 64'd5, 1'b1, 1'b1, 0, gs, go);
        chk("k_nborrow", gs, 65'h1_00000001);
        run_op(0, 64'h7FFFFFFF, 64'd1, 1'b0, 1'b0, 0, gs, go);
        chk("k_povf", gs, 65'h0_80000000);
        chk("k_povf_ovf", 65'(go), 65'd1);
        run_op(0, 64'h80000000, 64'd1, 1'b0, 1'b1, 5, gs, go);
        chk("k_novf", gs, 65'h1_7FFFFFFF);
        chk("k_novf_ovf", 65'(go), 65'd1);

        for (int d = 1; d < 3; d++) begin
            m  = (nw(d) == 64) ? '1 : ((64'd1 << nw(d)) - 64'd1);
            mn = 64'd1 << (nw(d) - 1);
            mp = mn - 64'd1;
            run_op(d, 64'd0, 64'd0, 1'b1, 1'b0, 0, gs, go);
            run_op(d, m, 64'd1, 1'b0, 1'b0, 0, gs, go);
            run_op(d, m, m, 1'b1, 1'b0, 0, gs, go);
            run_op(d, 64'd5, 64'd7, 1'b0, 1'b1, 0, gs, go);
            run_op(d, 64'd7, 64'd5, 1'b1, 1'b1, 2, gs, go);
            run_op(d, mp, 64'd1, 1'b0, 1'b0, 0, gs, go);
            run_op(d, mn, 64'd1, 1'b0, 1'b1, 0, gs, go);
        end

        a_v[0] = 64'h12345678;
        b_v[0] = 64'h0FEDCBA9;
        cin[0] = 1'b0;
        sb[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 65'(out_valid[0]), 65'd0);
        chk("mid_rst_rdy", 65'(in_ready[0]), 65'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_hold", 65'(out_valid[0]), 65'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_vld", 65'(out_valid[0]), 65'd0);
        run_op(0, 64'h12345678, 64'h0FEDCBA9, 1'b1, 1'b1, 0, gs, go);
        chk("k_post_rst", gs, 65'h1_02468ACE);

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 1000; i++) begin
                bp = ($urandom_range(0, 7) == 0) ?
                     int'($urandom_range(1, 3)) : 0;
                run_op(d, pick(nw(d)), pick(nw(d)),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       bp, gs, go);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
